muldiv_seq: RTL
===============

# muldiv_seq

Sequential signed multiply/divide unit that replaces the combinational multiplier and divider feeding the HI/LO registers of the multicycle CPU. It takes its operands from the ALU source multiplexer outputs and produces 64-bit results as `hi`/`lo`. It reports completion and the mult-overflow / div-by-zero flags to the control unit through a start/busy/done handshake.

## Interface
- `WIDTH`, default 32: operand width; also the number of iterations. Only 32 is required to work.

- `clk` in 1: the only clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: request a new operation; sampled only when `busy`=0.
- `op` in 1: 0 = signed multiply, 1 = signed divide; sampled with `start`.
- `a` in WIDTH: multiplicand or dividend (two's complement).
- `b` in WIDTH: multiplier or divisor (two's complement).
- `busy` out 1: operation in progress; `start` is ignored.
- `done` out 1: one-cycle completion pulse.
- `hi` out WIDTH: product[63:32] or remainder.
- `lo` out WIDTH: product[31:0] or quotient.
- `mult_overflow` out 1: valid with `done`; the product does not fit in 32 signed bits.
- `div_by_zero` out 1: valid with `done`; the divisor was 0.

## Operation
- States:
  - IDLE: waits for `start`.
  - CALC: one iteration per clock; a 6-bit counter runs from 0 to WIDTH-1.
  - FIX: sign correction and result write.
  - DONE: `done`=1.
- Start acceptance: `start` with `busy`=0 (IDLE or DONE) latches the operand magnitudes |a| and |b|, plus sa=a[31] and sb=b[31], clears the counter and enters CALC. |0x80000000| = 0x80000000 as unsigned.
- Divide by zero: `start`, `op`=1 and `b`=0 enters DONE directly, skipping CALC and FIX.
  - `div_by_zero`=1 in that DONE cycle.
  - `hi`/`lo` keep their previous values.
- Multiply, CALC: unsigned shift-add on a 64-bit accumulator.
- Multiply, FIX:
  - The 64-bit result is negated if sa^sb.
  - `mult_overflow` = (hi != {32{lo[31]}}).
- Divide, CALC: restoring division; remainder 33 bits, quotient 32 bits.
- Divide, FIX:
  - The quotient is negated if sa^sb; the remainder is negated if sa.
  - `lo`=quotient, `hi`=remainder.
  - 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0, with no flag.
- Flags:
  - `mult_overflow` and `div_by_zero` are cleared on every accepted `start`.
  - Each is updated only for its own op.
- Outputs `hi`/`lo` are registered and hold their value until the next FIX or divide-by-zero.
- Reset mid-operation aborts the operation. State goes to IDLE and all outputs go to 0.

## Timing
- Reset value: `busy`=0, `done`=0, `hi`=0, `lo`=0, flags 0, state IDLE, counter 0.
- Let edge E0 be the edge that samples `start`.
- Normal latency:
  - CALC occupies edges E1..E32.
  - FIX happens at E33.
  - `done`=1 in the cycle after E33.
  - `hi`/`lo` and the flags are valid in that same cycle.
- Divide-by-zero latency: `done`=1 in the cycle after E0.
- `busy`=1 in the CALC and FIX cycles only. It is 0 in IDLE and DONE.
- `done` lasts exactly one cycle. DONE→IDLE happens at the next edge unless `start` is present.
- Back-to-back: `start` in the DONE cycle is accepted. `done` drops and CALC begins at that edge.
- `start` while `busy`=1 is ignored, with no effect on state or outputs.
- Operands `a`/`b`/`op` may change freely after E0.

## Test plan
- Multiply 7 × 0xFFFFFFFD (−3):
  - Expect `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
  - Expect `mult_overflow`=0.
  - Expect `done` exactly 1 cycle long, in the cycle after E33.
- Multiply 0x80000000 × 0x80000000: expect `hi`=0x40000000, `lo`=0, `mult_overflow`=1.
- Divide 0xFFFFFFF9 (−7) / 2: expect `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF, `div_by_zero`=0.
- Divide 100 / 0 after a previous result of `hi`=5, `lo`=9:
  - Expect `done` and `div_by_zero`=1 in the cycle after E0.
  - Expect `hi`=5 and `lo`=9 unchanged.
  - Expect `busy` never 1.
- `start` pulsed at E10 during a multiply: expect no restart and the result still at E33.
- Reset (`reset`=0) at E15 during a multiply:
  - Expect all outputs 0 immediately.
  - Then a fresh divide 100/7 gives `lo`=14, `hi`=2.
- Back-to-back: `start` in a DONE cycle for 3×4 gives `done` again 33 edges later with `lo`=12.

Source files
------------

// File: rtl/muldiv_seq.sv
// Sequential signed multiply/divide unit for the HI/LO path: one shift-add or
// restoring-divide step per clock, sign fix-up in a final cycle, start/busy/done handshake.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             mult_overflow,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t               state, state_nxt;
    logic [5:0]           cnt;
    logic                 op_r, sa, sb;
    logic [WIDTH-1:0]     opa, opb;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH:0]       rem;
    logic                 accept, zdiv, last;
    logic [WIDTH:0]       msum, rem_sh, diff;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quo, rmd;

    // Magnitude of a two's-complement value; the most negative value maps to itself as unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] x);
        return x[WIDTH-1] ? $unsigned(-x) : $unsigned(x);
    endfunction

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x, input logic n);
        return n ? -x : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x, input logic n);
        return n ? -x : x;
    endfunction

    assign accept = start && (state == IDLE || state == DONE);
    assign zdiv   = op && (b == '0);
    assign last   = (cnt == 6'(WIDTH - 1));

    // Multiply keeps the multiplier in acc[W-1:0] and shifts the partial product in from the top;
    // divide shifts the dividend out of acc[W-1:0] while quotient bits shift in behind it.
    assign msum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opa : {WIDTH{1'b0}})};
    assign rem_sh = {rem[WIDTH-1:0], acc[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, opb};

    assign prod = neg_2w(acc, sa ^ sb);
    assign quo  = neg_w(acc[WIDTH-1:0], sa ^ sb);
    assign rmd  = neg_w(rem[WIDTH-1:0], sa);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) state_nxt = zdiv ? DONE : CALC;
                else       state_nxt = IDLE;
            end
            CALC:    if (last) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CALC) || (state == FIX);
        done = (state == DONE);
    end

    // Control and architectural outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt           <= '0;
            hi            <= '0;
            lo            <= '0;
            mult_overflow <= 1'b0;
            div_by_zero   <= 1'b0;
        end else begin
            if (accept) begin
                cnt           <= '0;
                mult_overflow <= 1'b0;
                div_by_zero   <= zdiv;
            end else if (state == CALC) begin
                cnt <= cnt + 6'd1;
            end
            if (state == FIX) begin
                if (op_r) begin
                    hi <= rmd;
                    lo <= quo;
                end else begin
                    hi            <= prod[2*WIDTH-1:WIDTH];
                    lo            <= prod[WIDTH-1:0];
                    mult_overflow <= (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
                end
            end
        end
    end

    // Iteration datapath
    always_ff @(posedge clk) begin
        if (accept) begin
            op_r <= op;
            sa   <= a[WIDTH-1];
            sb   <= b[WIDTH-1];
            opa  <= mag(a);
            opb  <= mag(b);
            acc  <= {{WIDTH{1'b0}}, (op ? mag(a) : mag(b))};
            rem  <= '0;
        end else if (state == CALC) begin
            if (op_r) begin
                rem            <= diff[WIDTH] ? rem_sh : diff;
                acc[WIDTH-1:0] <= {acc[WIDTH-2:0], ~diff[WIDTH]};
            end else begin
                acc <= {msum, acc[WIDTH-1:1]};
            end
        end
    end

endmodule
